inst_fetch_queue: RTL and testbench



---
 rtl/inst_fetch_queue.sv | 177 +++++++++++++++++
 tb/tb_inst_fetch_queue.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch_queue.sv
// -----------------------------------------------------------------------------
// inst_fetch_queue
//
// Fetch stage for the single-cycle decode/execute block. It owns the fetch PC,
// presents that PC to the instruction memory and buffers the returned
// {PC, instruction} pairs in a small FIFO. Decode pops the head entry through
// a valid/ready handshake.
//
// A taken branch/jump redirect flushes every buffered entry and restarts
// fetching at the new target. Fetching stops after an ECALL word is buffered.
// Entries that are already queued still drain while halted. Only a redirect or
// a reset restarts fetching.
//
// Optional feature (macro IFQ_BYPASS_EN):
//   When the FIFO is empty, the state is FETCH and no redirect is requested,
//   the memory word goes straight to decode in the same cycle. If decode takes
//   it, the word is never written into the FIFO. Without the macro, decode
//   only ever sees FIFO storage, so the minimum latency is one cycle.
//
// Parameters:
//   DEPTH     FIFO entries (power of two, >= 2)
//   RESET_PC  PC loaded on reset
//   PTR_W     pointer width, log2(DEPTH)
//
// Ports:
//   CLK         rising-edge clock
//   RST         synchronous active-high reset
//   IMEM_ADDR   instruction memory address (current fetch PC)
//   IMEM_INST   instruction word, combinational from IMEM_ADDR
//   INST_OUT    instruction at the FIFO head (0 while empty)
//   PC_OUT      PC of the FIFO head (0 while empty)
//   INST_VALID  head entry is valid
//   INST_READY  decode accepts the head this cycle
//   REDIR_EN    redirect request (taken branch/jump)
//   REDIR_PC    redirect target, low two bits ignored
//   COUNT       number of occupied entries
//   HALTED      fetch stopped after ECALL
// -----------------------------------------------------------------------------
module inst_fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          PTR_W    = 2
) (
  input  logic             CLK,
  input  logic             RST,
  output logic [31:0]      IMEM_ADDR,
  input  logic [31:0]      IMEM_INST,
  output logic [31:0]      INST_OUT,
  output logic [31:0]      PC_OUT,
  output logic             INST_VALID,
  input  logic             INST_READY,
  input  logic             REDIR_EN,
  input  logic [31:0]      REDIR_PC,
  output logic [PTR_W:0]   COUNT,
  output logic             HALTED
);

  typedef enum logic {
    FETCH = 1'b0,
    HALT  = 1'b1
  } state_t;

  localparam logic [31:0]    ECALL_WORD = 32'h0000_0073;
  localparam logic [PTR_W:0] FULL_COUNT = DEPTH[PTR_W:0];

  state_t state;
  state_t state_next;

  logic [31:0]    pc_q;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W:0] count;

  logic [31:0] pc_store   [DEPTH];
  logic [31:0] inst_store [DEPTH];

  logic        fifo_valid;
  logic        bypass;
  logic        pop;
  logic        push;
  logic        consume;
  logic        advance;
  logic        is_ecall;
  logic [31:0] redir_target;

  // Masking keeps every bit of REDIR_PC in use and word-aligns the target.
  assign redir_target = REDIR_PC & 32'hFFFF_FFFC;

  assign IMEM_ADDR = pc_q;
  assign COUNT     = count;
  assign HALTED    = (state == HALT);

  // State register. Reset always returns the machine to FETCH.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= FETCH;
    end else begin
      state <= state_next;
    end
  end

  // Handshake decode, head-of-queue outputs and next-state logic.
  always_comb begin
    state_next = state;
    fifo_valid = (count != '0);
`ifdef IFQ_BYPASS_EN
    bypass     = (count == '0) && (state == FETCH) && !REDIR_EN;
`else
    bypass     = 1'b0;
`endif
    INST_VALID = fifo_valid || bypass;
    INST_OUT   = '0;
    PC_OUT     = '0;
    if (bypass) begin
      INST_OUT = IMEM_INST;
      PC_OUT   = pc_q;
    end else if (fifo_valid) begin
      INST_OUT = inst_store[rd_ptr];
      PC_OUT   = pc_store[rd_ptr];
    end

    // A full FIFO can still accept a push if the head leaves in the same cycle.
    pop      = fifo_valid && INST_READY;
    consume  = bypass && INST_READY;
    push     = (state == FETCH) && !REDIR_EN && !consume &&
               ((count != FULL_COUNT) || pop);
    advance  = push || consume;
    is_ecall = (IMEM_INST == ECALL_WORD);

    if (REDIR_EN) begin
      state_next = FETCH;
    end else if (advance && is_ecall) begin
      state_next = HALT;
    end
  end

  // PC, pointers and occupancy. A redirect flushes the queue even if decode
  // popped in the same cycle. The fetch PC simply wraps at 32 bits.
  always_ff @(posedge CLK) begin
    if (RST) begin
      pc_q   <= RESET_PC;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (REDIR_EN) begin
      pc_q   <= redir_target;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (advance) begin
        pc_q <= pc_q + 32'd4;
      end
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (push && !pop) begin
        count <= count + 1'b1;
      end else if (pop && !push) begin
        count <= count - 1'b1;
      end
    end
  end

  // Entry storage needs no reset. An entry is only read when COUNT says it
  // holds live data.
  always_ff @(posedge CLK) begin
    if (!RST && push) begin
      pc_store[wr_ptr]   <= pc_q;
      inst_store[wr_ptr] <= IMEM_INST;
    end
  end

endmodule

// File: tb/tb_inst_fetch_queue.sv
// -----------------------------------------------------------------------------
// tb_inst_fetch_queue
//
// Self-checking bench for inst_fetch_queue (default build, bypass disabled).
//
// A reference model follows the fetch rules at the level of a queue of
// {pc, inst} entries:
//   - On each rising edge, fetch the next word if the queue has room.
//   - Halt after an ECALL word.
//   - Clear the queue on a redirect or a reset.
//
// Each fetched entry is pushed into the expected queue. A monitor samples the
// DUT shortly after each falling edge. On every accepted handshake it pops the
// next expected entry and compares it. It also compares COUNT, INST_VALID,
// IMEM_ADDR and HALTED against the model every cycle.
// -----------------------------------------------------------------------------
module tb_inst_fetch_queue;

  localparam int          DEPTH = 4;
  localparam int          PTR_W = 2;
  localparam logic [31:0] ECALL = 32'h0000_0073;

  logic             CLK = 1'b0;
  logic             RST;
  logic [31:0]      IMEM_ADDR;
  logic [31:0]      IMEM_INST;
  logic [31:0]      INST_OUT;
  logic [31:0]      PC_OUT;
  logic             INST_VALID;
  logic             INST_READY;
  logic             REDIR_EN;
  logic [31:0]      REDIR_PC;
  logic [PTR_W:0]   COUNT;
  logic             HALTED;

  logic [31:0] imem [256];
  logic [31:0] imem_normal_2;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } entry_t;

  entry_t      exp_q [$];
  logic [31:0] model_pc;
  bit          model_halted;
  bit          model_live;

  int checks;
  int errors;

  always #5 CLK = ~CLK;

  assign IMEM_INST = imem[IMEM_ADDR[9:2]];

  inst_fetch_queue #(
    .DEPTH    (DEPTH),
    .RESET_PC (32'h0000_0000),
    .PTR_W    (PTR_W)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .IMEM_ADDR  (IMEM_ADDR),
    .IMEM_INST  (IMEM_INST),
    .INST_OUT   (INST_OUT),
    .PC_OUT     (PC_OUT),
    .INST_VALID (INST_VALID),
    .INST_READY (INST_READY),
    .REDIR_EN   (REDIR_EN),
    .REDIR_PC   (REDIR_PC),
    .COUNT      (COUNT),
    .HALTED     (HALTED)
  );

  task automatic compare_value(input string name, input logic [31:0] act,
                               input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one set of inputs for n cycles, changing them on falling edges.
  task automatic applyStimulus(input bit rst, input bit ready, input bit redir,
                               input logic [31:0] rpc, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge CLK);
      RST        = rst;
      INST_READY = ready;
      REDIR_EN   = redir;
      REDIR_PC   = rpc;
    end
  endtask

  // Compare per-cycle state, then score the handshake if decode takes the head.
  task automatic checkOutput();
    entry_t e;
    compare_value("count", 32'(COUNT), 32'(exp_q.size()));
    compare_value("inst_valid", 32'(INST_VALID), 32'(exp_q.size() != 0));
    compare_value("imem_addr", IMEM_ADDR, model_pc);
    compare_value("halted", 32'(HALTED), 32'(model_halted));
    if (INST_VALID === 1'b1 && INST_READY === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL pop_empty: got pc %h, expected no entry", PC_OUT);
      end else begin
        e = exp_q.pop_front();
        compare_value("pc_out", PC_OUT, e.pc);
        compare_value("inst_out", INST_OUT, e.inst);
      end
    end else if (INST_VALID === 1'b0) begin
      compare_value("pc_out_empty", PC_OUT, 32'h0);
      compare_value("inst_out_empty", INST_OUT, 32'h0);
    end
  endtask

  // Monitor: sample one time unit after the falling edge, when inputs are stable.
  always @(negedge CLK) begin
    #1;
    if (model_live) begin
      checkOutput();
    end
  end

  // Reference model. It updates on the same edge as the DUT. Handshakes this
  // cycle were already removed from exp_q by the monitor, so a free slot in
  // the queue is exactly the condition for a new fetch.
  always @(posedge CLK) begin
    entry_t e;
    if (RST === 1'b1) begin
      exp_q.delete();
      model_pc     = 32'h0;
      model_halted = 1'b0;
      model_live   = 1'b1;
    end else if (model_live) begin
      if (REDIR_EN === 1'b1) begin
        exp_q.delete();
        model_pc     = {REDIR_PC[31:2], 2'b00};
        model_halted = 1'b0;
      end else if (!model_halted && exp_q.size() < DEPTH) begin
        e.pc   = model_pc;
        e.inst = imem[model_pc[9:2]];
        exp_q.push_back(e);
        if (e.inst == ECALL) begin
          model_halted = 1'b1;
        end
        model_pc = model_pc + 32'd4;
      end
    end
  end

  initial begin
    logic [31:0] w;
    logic [31:0] rpc;
    bit          rst;
    bit          redir;
    bit          ready;

    checks       = 0;
    errors       = 0;
    model_live   = 1'b0;
    model_halted = 1'b0;
    model_pc     = 32'h0;
    RST          = 1'b1;
    INST_READY   = 1'b0;
    REDIR_EN     = 1'b0;
    REDIR_PC     = 32'h0;

    for (int i = 0; i < 256; i++) begin
      w = $urandom;
      if (w == ECALL) w = w + 32'd1;
      imem[i] = w;
    end
    imem[0] = 32'h00A0_0093;
    imem[1] = 32'h0010_0113;
    imem_normal_2 = imem[2];

    // Reset, then stream with decode always ready.
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 2);
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 8);

    // Back-pressure: fill to DEPTH and hold, then drain in order.
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 10);
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 6);

    // Build COUNT=3, then redirect to an unaligned target.
    applyStimulus(1'b0, 1'b0, 1'b1, 32'h0, 1);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 3);
    applyStimulus(1'b0, 1'b0, 1'b1, 32'h0000_0102, 1);
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 3);

    // ECALL at PC 8: halt, drain, then leave via redirect to 0x40.
    imem[2] = ECALL;
    applyStimulus(1'b0, 1'b0, 1'b1, 32'h0, 1);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 6);
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 5);
    applyStimulus(1'b0, 1'b1, 1'b1, 32'h0000_0040, 1);
    imem[2] = imem_normal_2;
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 4);

    // Full FIFO with a simultaneous pop appends the new entry.
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 6);
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 1);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1);

    // Reset beats a redirect in the same cycle.
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 5);
    applyStimulus(1'b1, 1'b0, 1'b1, 32'h0000_0080, 1);
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 3);

    // PC wrap from 0xFFFF_FFFC to 0, streaming and under back-pressure.
    applyStimulus(1'b0, 1'b1, 1'b1, 32'hFFFF_FFF4, 1);
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 6);
    applyStimulus(1'b0, 1'b1, 1'b1, 32'hFFFF_FFF8, 1);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 4);
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 5);

    // Randomized traffic with a few ECALL words scattered through memory.
    for (int i = 0; i < 8; i++) begin
      imem[$urandom_range(255, 0)] = ECALL;
    end
    for (int i = 0; i < 400; i++) begin
      rst   = ($urandom_range(99, 0) == 0);
      redir = ($urandom_range(15, 0) == 0);
      ready = ($urandom_range(2, 0) != 0);
      if ($urandom_range(3, 0) == 0) begin
        rpc = 32'hFFFF_FFF0 + 32'($urandom_range(15, 0));
      end else begin
        rpc = $urandom;
      end
      applyStimulus(rst, ready, redir, rpc, 1);
    end

    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 2);
    @(negedge CLK);
    #2;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
